// File: rtl/latch_wr_pkg.sv
// rtl/latch_wr_pkg.sv - state type, sizing helpers and parameter legality for the latch write sequencer
package latch_wr_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_e;

    localparam int MIN_NUM_LATCH = 2;
    localparam int MIN_PULSE_CYC = 1;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    function automatic bit params_legal(input int num_latch, input int setup_cyc,
                                        input int pulse_cyc, input int hold_cyc);
        return (num_latch >= MIN_NUM_LATCH) && (setup_cyc >= 0) &&
               (pulse_cyc >= MIN_PULSE_CYC) && (hold_cyc >= 0);
    endfunction

endpackage

// File: rtl/cyc_down_counter.sv
// rtl/cyc_down_counter.sv - loadable down-counter that saturates at zero and flags it
module cyc_down_counter #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/latch_write_ctrl.sv
// rtl/latch_write_ctrl.sv - sequences one latch write: data setup, one-hot enable pulse, data hold
module latch_write_ctrl
    import latch_wr_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int NUM_LATCH = 4,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1,
    localparam int ADDR_W   = clog2(NUM_LATCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic [ADDR_W-1:0]    req_addr,
    input  logic [DATA_W-1:0]    req_data,
    output logic [DATA_W-1:0]    lat_d,
    output logic [NUM_LATCH-1:0] lat_en,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);

    localparam bit PARAMS_OK = params_legal(NUM_LATCH, SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int MAX_CYC   = max3(SETUP_CYC, PULSE_CYC, HOLD_CYC);
    localparam int CNT_W     = (clog2(MAX_CYC + 1) < 1) ? 1 : clog2(MAX_CYC + 1);

    // Each phase lasts N cycles, so the counter is loaded with N-1 and the phase ends on zero.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'((SETUP_CYC > 0) ? SETUP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'((PULSE_CYC > 0) ? PULSE_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'((HOLD_CYC > 0) ? HOLD_CYC - 1 : 0);
    localparam logic [ADDR_W:0]  NUM_LATCH_W = (ADDR_W + 1)'(NUM_LATCH);

    generate
        if (!PARAMS_OK) begin : g_bad_params
            $error("latch_write_ctrl: illegal parameters (PULSE_CYC >= 1 and NUM_LATCH >= 2 required)");
        end
    endgenerate

    state_e                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  oor_q, oor_d;
    logic [DATA_W-1:0]     lat_d_q, lat_d_d;
    logic [NUM_LATCH-1:0]  lat_en_q, lat_en_d;
    logic                  done_q, done_d;
    logic                  err_q;
    logic                  busy_q;
    logic                  ready_q;
    logic                  cnt_load;
    logic [CNT_W-1:0]      cnt_load_val;
    logic                  cnt_zero;

    cyc_down_counter #(
        .CNT_W(CNT_W)
    ) u_cnt (
        .clk       (clk),
        .rst       (rst),
        .load_i    (cnt_load),
        .load_val_i(cnt_load_val),
        .dec_i     (state_q != IDLE),
        .zero_o    (cnt_zero)
    );

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        oor_d        = oor_q;
        lat_d_d      = lat_d_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;

        case (state_q)
            IDLE: begin
                if (req_valid && ready_q) begin
                    addr_d   = req_addr;
                    oor_d    = ({1'b0, req_addr} >= NUM_LATCH_W);
                    lat_d_d  = req_data;
                    cnt_load = 1'b1;
                    if (SETUP_CYC > 0) begin
                        state_d      = SETUP;
                        cnt_load_val = SETUP_LD;
                    end else begin
                        state_d      = PULSE;
                        cnt_load_val = PULSE_LD;
                    end
                end
            end
            SETUP: begin
                if (cnt_zero) begin
                    state_d      = PULSE;
                    cnt_load     = 1'b1;
                    cnt_load_val = PULSE_LD;
                end
            end
            PULSE: begin
                if (cnt_zero) begin
                    if (HOLD_CYC > 0) begin
                        state_d      = HOLD;
                        cnt_load     = 1'b1;
                        cnt_load_val = HOLD_LD;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            HOLD: begin
                if (cnt_zero) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Enables are decoded from the next state so the registered output is glitch-free.
        lat_en_d = '0;
        if ((state_d == PULSE) && !oor_d) begin
            for (int i = 0; i < NUM_LATCH; i++) begin
                lat_en_d[i] = (addr_d == ADDR_W'(i));
            end
        end

        done_d = (state_q != IDLE) && (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            oor_q    <= 1'b0;
            lat_d_q  <= '0;
            lat_en_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            oor_q    <= oor_d;
            lat_d_q  <= lat_d_d;
            lat_en_q <= lat_en_d;
            done_q   <= done_d;
            err_q    <= done_d && oor_q;
            busy_q   <= (state_d != IDLE);
            ready_q  <= (state_d == IDLE);
        end
    end

    assign req_ready = ready_q;
    assign lat_d     = lat_d_q;
    assign lat_en    = lat_en_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: tb/tb_latch_write_ctrl.sv
// tb/tb_latch_write_ctrl.sv - randomized timeline-model bench for latch_write_ctrl over three parameter sets
module tb_latch_write_ctrl;

    localparam int MAXC = 512;
    localparam int S_P[3] = '{1, 1, 0};
    localparam int P_P[3] = '{2, 2, 1};
    localparam int H_P[3] = '{1, 1, 0};
    localparam int N_P[3] = '{4, 3, 4};

    typedef struct {
        logic [1:0] addr;
        logic [7:0] data;
    } req_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic       vld [3];
    logic [1:0] adr [3];
    logic [7:0] dat [3];

    logic       rdy_a, busy_a, done_a, err_a;
    logic [7:0] d_a;
    logic [3:0] en_a;
    logic       rdy_b, busy_b, done_b, err_b;
    logic [7:0] d_b;
    logic [2:0] en_b;
    logic       rdy_c, busy_c, done_c, err_c;
    logic [7:0] d_c;
    logic [3:0] en_c;

    int         sel = 0;
    logic       o_rdy, o_busy, o_done, o_err;
    logic [7:0] o_d;
    logic [3:0] o_en;

    int   checks = 0;
    int   failures = 0;
    logic [7:0] cur_d [3];
    req_t plan [$];

    latch_write_ctrl dut_a (
        .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy_a), .req_addr(adr[0]),
        .req_data(dat[0]), .lat_d(d_a), .lat_en(en_a), .busy(busy_a), .done(done_a), .err(err_a)
    );

    latch_write_ctrl #(.NUM_LATCH(3)) dut_b (
        .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy_b), .req_addr(adr[1]),
        .req_data(dat[1]), .lat_d(d_b), .lat_en(en_b), .busy(busy_b), .done(done_b), .err(err_b)
    );

    latch_write_ctrl #(.SETUP_CYC(0), .PULSE_CYC(1), .HOLD_CYC(0)) dut_c (
        .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy_c), .req_addr(adr[2]),
        .req_data(dat[2]), .lat_d(d_c), .lat_en(en_c), .busy(busy_c), .done(done_c), .err(err_c)
    );

    always_comb begin
        case (sel)
            1: begin
                o_rdy = rdy_b; o_busy = busy_b; o_done = done_b; o_err = err_b;
                o_d = d_b; o_en = {1'b0, en_b};
            end
            2: begin
                o_rdy = rdy_c; o_busy = busy_c; o_done = done_c; o_err = err_c;
                o_d = d_c; o_en = en_c;
            end
            default: begin
                o_rdy = rdy_a; o_busy = busy_a; o_done = done_a; o_err = err_a;
                o_d = d_a; o_en = en_a;
            end
        endcase
    end

    // Expected waveform is written as a timeline: each accept stamps its phases onto future cycles.
    task automatic run_session(input int k, input int ncyc, input bit rnd);
        logic [3:0] e_en   [MAXC];
        logic [7:0] e_d    [MAXC];
        bit         e_done [MAXC];
        bit         e_err  [MAXC];
        bit         e_busy [MAXC];
        int         free, c, tot;
        bit         from_plan;
        tot = S_P[k] + P_P[k] + H_P[k];
        for (int i = 0; i < MAXC; i++) begin
            e_en[i] = '0; e_d[i] = cur_d[k]; e_done[i] = 0; e_err[i] = 0; e_busy[i] = 0;
        end
        free = 0;
        c = 0;
        sel = k;
        while ((c < ncyc || c <= free) && c < MAXC - tot - 2) begin
            @(posedge clk);
            #1;
            from_plan = 0;
            if (c < ncyc && plan.size() > 0) begin
                vld[k] = 1'b1; adr[k] = plan[0].addr; dat[k] = plan[0].data; from_plan = 1;
            end else if (c < ncyc && rnd) begin
                vld[k] = 1'($urandom_range(0, 1)); adr[k] = 2'($urandom); dat[k] = 8'($urandom);
            end else begin
                vld[k] = 1'b0; adr[k] = 2'($urandom); dat[k] = 8'($urandom);
            end
            @(negedge clk);
            checks += 6;
            if (o_en !== e_en[c]) begin
                failures++; $display("FAIL lat_en k=%0d cyc=%0d got=%b exp=%b", k, c, o_en, e_en[c]);
            end
            if (o_d !== e_d[c]) begin
                failures++; $display("FAIL lat_d k=%0d cyc=%0d got=%h exp=%h", k, c, o_d, e_d[c]);
            end
            if (o_done !== e_done[c]) begin
                failures++; $display("FAIL done k=%0d cyc=%0d got=%b exp=%b", k, c, o_done, e_done[c]);
            end
            if (o_err !== e_err[c]) begin
                failures++; $display("FAIL err k=%0d cyc=%0d got=%b exp=%b", k, c, o_err, e_err[c]);
            end
            if (o_busy !== e_busy[c]) begin
                failures++; $display("FAIL busy k=%0d cyc=%0d got=%b exp=%b", k, c, o_busy, e_busy[c]);
            end
            if (o_rdy !== !e_busy[c]) begin
                failures++; $display("FAIL req_ready k=%0d cyc=%0d got=%b exp=%b", k, c, o_rdy, !e_busy[c]);
            end
            if (vld[k] && c >= free) begin
                for (int i = c + 1; i <= c + tot; i++) e_busy[i] = 1;
                for (int i = c + S_P[k] + 1; i <= c + S_P[k] + P_P[k]; i++)
                    e_en[i] = (int'(adr[k]) < N_P[k]) ? (4'b0001 << adr[k]) : 4'b0000;
                for (int i = c + 1; i < MAXC; i++) e_d[i] = dat[k];
                e_done[c + tot + 1] = 1;
                e_err[c + tot + 1] = (int'(adr[k]) >= N_P[k]);
                free = c + tot + 1;
                cur_d[k] = dat[k];
                if (from_plan) void'(plan.pop_front());
            end
            c++;
        end
        if (plan.size() > 0) begin
            failures++;
            $display("FAIL plan_drain k=%0d left=%0d exp=0", k, plan.size());
            plan.delete();
        end
        vld[k] = 1'b0;
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #2;
        for (int k = 0; k < 3; k++) begin
            sel = k;
            #0;
            checks += 4;
            if (o_en !== 4'b0) begin failures++; $display("FAIL rst_en k=%0d got=%b exp=0", k, o_en); end
            if (o_d !== 8'h00) begin failures++; $display("FAIL rst_d k=%0d got=%h exp=00", k, o_d); end
            if (o_rdy !== 1'b1) begin failures++; $display("FAIL rst_ready k=%0d got=%b exp=1", k, o_rdy); end
            if ({o_busy, o_done, o_err} !== 3'b000) begin
                failures++; $display("FAIL rst_flags k=%0d got=%b exp=000", k, {o_busy, o_done, o_err});
            end
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cur_d[k] = 8'h00;
    endtask

    task automatic test_defaults();
        plan.push_back('{2'd2, 8'hA5});
        run_session(0, 3, 0);
    endtask

    task automatic test_back_to_back();
        plan.push_back('{2'd1, 8'h3C});
        plan.push_back('{2'd3, 8'hC3});
        run_session(0, 10, 0);
    endtask

    task automatic test_out_of_range();
        plan.push_back('{2'd3, 8'hFF});
        run_session(1, 3, 0);
        plan.push_back('{2'd2, 8'h5A});
        plan.push_back('{2'd3, 8'h01});
        run_session(1, 12, 0);
    endtask

    task automatic test_param_corners();
        plan.push_back('{2'd0, 8'h11});
        plan.push_back('{2'd3, 8'h22});
        run_session(2, 4, 0);
    endtask

    task automatic test_reset_mid_pulse();
        sel = 0;
        @(posedge clk); #1; vld[0] = 1'b1; adr[0] = 2'd2; dat[0] = 8'hA5;
        @(posedge clk); #1; vld[0] = 1'b0; adr[0] = 2'd1; dat[0] = 8'h77;
        @(posedge clk); #1;
        checks++;
        if (o_en !== 4'b0100) begin failures++; $display("FAIL mid_pulse_en got=%b exp=0100", o_en); end
        rst = 1'b1;
        #1;
        checks += 4;
        if (o_en !== 4'b0) begin failures++; $display("FAIL rst_async_en got=%b exp=0000", o_en); end
        if (o_d !== 8'h00) begin failures++; $display("FAIL rst_async_d got=%h exp=00", o_d); end
        if (o_rdy !== 1'b1) begin failures++; $display("FAIL rst_async_ready got=%b exp=1", o_rdy); end
        if (o_busy !== 1'b0) begin failures++; $display("FAIL rst_async_busy got=%b exp=0", o_busy); end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) cur_d[k] = 8'h00;
        run_session(0, 6, 0);
        plan.push_back('{2'd0, 8'h96});
        run_session(0, 3, 0);
    endtask

    task automatic test_input_stability();
        plan.push_back('{2'd1, 8'h42});
        run_session(0, 30, 1);
        plan.push_back('{2'd0, 8'hBD});
        run_session(2, 20, 1);
    endtask

    task automatic test_random();
        for (int k = 0; k < 3; k++) run_session(k, 150, 1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            vld[k] = 1'b0; adr[k] = '0; dat[k] = '0; cur_d[k] = '0;
        end
        test_reset();
        test_defaults();
        test_back_to_back();
        test_out_of_range();
        test_param_corners();
        test_reset_mid_pulse();
        test_input_stability();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
